// File: rtl/gl_cmd_writer.sv
// gl_cmd_writer: producer end of the GL instruction BRAM.
// Accepts header/operand words and writes each command into consecutive
// BRAM byte addresses. wr_ptr advances only once a whole command is stored.
// Optional tail terminator write after every command: define GL_CMD_WRITER_TERM_EN.
module gl_cmd_writer #(
  parameter int unsigned text_start = 0,
  parameter int unsigned mem_bytes  = 4096,
  parameter int unsigned width      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [width-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             bram_we,
  output logic [width-1:0] bram_addr,
  output logic [width-1:0] bram_wdata,
  output logic [width-1:0] wr_ptr,
  output logic             busy,
  output logic             full
);

  localparam logic [width-1:0] START = width'(text_start);
  localparam logic [width:0]   LIMIT = {1'b0, START} + (width+1)'(mem_bytes);
  localparam logic [width-1:0] WSTEP = width'(4);

`ifdef GL_CMD_WRITER_TERM_EN
  typedef enum logic [1:0] {S_IDLE, S_OPND, S_COMMIT, S_TERM} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_OPND, S_COMMIT} state_e;
`endif

  state_e           state_q;
  logic [width-1:0] waddr_q;
  logic [4:0]       remain_q;
  logic [width-1:0] wr_ptr_q;
  logic             full_q;
  logic             we_q;
  logic [width-1:0] addr_q;
  logic [width-1:0] wdata_q;

  logic [6:0]       len_bytes;
  logic [4:0]       hdr_words;
  logic             fits;

  // Command length in bytes, decoded from the header opcode.
  function automatic logic [6:0] cmd_len(input logic [7:0] op);
    case (op)
      8'h03, 8'h04:                      cmd_len = 7'd16;
      8'h11, 8'h13, 8'h16, 8'h17, 8'h18: cmd_len = 7'd68;
      8'h19:                             cmd_len = 7'd20;
      8'h1A:                             cmd_len = 7'd28;
      default:                           cmd_len = 7'd4;
    endcase
  endfunction

  assign len_bytes = cmd_len(in_data[7:0]);
  assign hdr_words = len_bytes[6:2];
  // One extra bit so a command ending exactly at the top of memory cannot wrap.
  assign fits      = ({1'b0, waddr_q} + (width+1)'(len_bytes)) <= LIMIT;

  // Ready: whole command must fit before a header is taken; operands always flow.
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      S_IDLE:  in_ready = in_valid && fits;
      S_OPND:  in_ready = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  // Command FSM, registered BRAM write port, pointer commit and sticky full flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      waddr_q  <= START;
      wr_ptr_q <= START;
      remain_q <= '0;
      full_q   <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= START;
      wdata_q  <= '0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (in_valid && fits) begin
            we_q     <= 1'b1;
            addr_q   <= waddr_q;
            wdata_q  <= in_data;
            waddr_q  <= waddr_q + WSTEP;
            remain_q <= hdr_words - 5'd1;
            state_q  <= (hdr_words == 5'd1) ? S_COMMIT : S_OPND;
          end else if (in_valid) begin
            full_q <= 1'b1;
          end
        end
        S_OPND: begin
          if (in_valid) begin
            we_q     <= 1'b1;
            addr_q   <= waddr_q;
            wdata_q  <= in_data;
            waddr_q  <= waddr_q + WSTEP;
            remain_q <= remain_q - 5'd1;
            if (remain_q == 5'd1) begin
              state_q <= S_COMMIT;
            end
          end
        end
        S_COMMIT: begin
          wr_ptr_q <= waddr_q;
`ifdef GL_CMD_WRITER_TERM_EN
          state_q  <= S_TERM;
`else
          state_q  <= S_IDLE;
`endif
        end
`ifdef GL_CMD_WRITER_TERM_EN
        S_TERM: begin
          // Zero word at the new tail; skipped when the tail is the end of memory.
          if ({1'b0, waddr_q} != LIMIT) begin
            we_q    <= 1'b1;
            addr_q  <= waddr_q;
            wdata_q <= '0;
          end
          state_q <= S_IDLE;
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bram_we    = we_q;
  assign bram_addr  = addr_q;
  assign bram_wdata = wdata_q;
  assign wr_ptr     = wr_ptr_q;
  assign full       = full_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_gl_cmd_writer.sv
// Self-checking bench for gl_cmd_writer: directed scenarios with literal
// expectations plus randomized command streams checked every cycle against
// a transaction-level model of the writer.
module tb_gl_cmd_writer;

  localparam longint END = 4096;
`ifdef GL_CMD_WRITER_TERM_EN
  localparam int TERM_EN = 1;
  localparam int GAP0    = 2;
`else
  localparam int TERM_EN = 0;
  localparam int GAP0    = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main DUT (4 KiB)
  logic        reset, in_valid, in_ready, bram_we, busy, full;
  logic [31:0] in_data, bram_addr, bram_wdata, wr_ptr;
  // small DUT (32 bytes)
  logic        s_reset, s_valid, s_ready, s_we, s_busy, s_full;
  logic [31:0] s_data, s_addr, s_wdata, s_wr_ptr;

  gl_cmd_writer #(.text_start(0), .mem_bytes(4096), .width(32)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_wdata(bram_wdata), .wr_ptr(wr_ptr), .busy(busy), .full(full));

  gl_cmd_writer #(.text_start(0), .mem_bytes(32), .width(32)) dut_small (
    .clk(clk), .reset(s_reset), .in_data(s_data), .in_valid(s_valid),
    .in_ready(s_ready), .bram_we(s_we), .bram_addr(s_addr),
    .bram_wdata(s_wdata), .wr_ptr(s_wr_ptr), .busy(s_busy), .full(s_full));

  int checks   = 0;
  int failures = 0;
  longint cycle = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  function automatic int bytes_for(input logic [7:0] op);
    case (op)
      8'h03, 8'h04:                      return 16;
      8'h11, 8'h13, 8'h16, 8'h17, 8'h18: return 68;
      8'h19:                             return 20;
      8'h1A:                             return 28;
      default:                           return 4;
    endcase
  endfunction

  // ---------------- reference model (main DUT) ----------------
  longint      m_cur, m_tail;   // next free byte, committed tail
  int          m_left;          // words still owed by the open command
  int          m_gap;           // dead cycles still owed after a command
  bit          m_full;
  bit          e_we;
  logic [31:0] e_addr, e_data;
  bit          live = 1'b0;

  // write log for directed checks
  bit          log_en = 1'b0;
  int          log_n  = 0;
  logic [31:0] log_addr [256];
  logic [31:0] log_data [256];
  longint      log_cyc  [256];

  always @(negedge clk) begin
    bit exp_rdy;
    int n;
    cycle++;
    if (live) begin
      if (m_left > 0)     exp_rdy = 1'b1;
      else if (m_gap > 0) exp_rdy = 1'b0;
      else                exp_rdy = in_valid && (m_cur + bytes_for(in_data[7:0]) <= END);
      chk("in_ready", in_ready, exp_rdy);
      chk("bram_we", bram_we, e_we);
      if (e_we) begin
        chk("bram_addr", bram_addr, e_addr);
        chk("bram_wdata", bram_wdata, e_data);
      end
      chk("wr_ptr", wr_ptr, m_tail);
      chk("busy", busy, (m_left > 0) || (m_gap > 0));
      chk("full", full, m_full);
    end
    if (log_en && bram_we === 1'b1 && log_n < 256) begin
      log_addr[log_n] = bram_addr;
      log_data[log_n] = bram_wdata;
      log_cyc[log_n]  = cycle;
      log_n++;
    end
    // advance model across the coming rising edge
    if (reset === 1'b0) begin
      m_cur = 0; m_tail = 0; m_left = 0; m_gap = 0; m_full = 1'b0;
      e_we = 1'b0; e_addr = '0; e_data = '0;
      live = 1'b1;
    end else if (live) begin
      e_we = 1'b0;
      if (m_left > 0) begin
        if (in_valid) begin
          e_we = 1'b1; e_addr = 32'(m_cur); e_data = in_data;
          m_cur += 4; m_left--;
          if (m_left == 0) m_gap = GAP0;
        end
      end else if (m_gap > 0) begin
        if (m_gap == GAP0) m_tail = m_cur;
        if (TERM_EN != 0 && m_gap == 1 && m_cur != END) begin
          e_we = 1'b1; e_addr = 32'(m_cur); e_data = '0;
        end
        m_gap--;
      end else if (in_valid) begin
        n = bytes_for(in_data[7:0]);
        if (m_cur + n <= END) begin
          e_we = 1'b1; e_addr = 32'(m_cur); e_data = in_data;
          m_cur += 4; m_left = n / 4 - 1;
          if (m_left == 0) m_gap = GAP0;
        end else begin
          m_full = 1'b1;
        end
      end
    end
  end

  // ---------------- stimulus helpers (main DUT) ----------------
  task automatic send_word(input logic [31:0] w, input int bound, output bit ok);
    in_data = w; in_valid = 1'b1; ok = 1'b0;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        ok = 1'b1;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic rst_pulse(input int n);
    reset = 1'b0; in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
    reset = 1'b1;
  endtask

  logic [7:0] OPS [9] = '{8'h03, 8'h04, 8'h11, 8'h13, 8'h16, 8'h17, 8'h18, 8'h19, 8'h1A};

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int base;
    reset = 1'b0; in_valid = 1'b0; in_data = '0;
    s_reset = 1'b0; s_valid = 1'b0; s_data = '0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1; s_reset = 1'b1;

    // reset state
    chk("rst_wr_ptr", wr_ptr, 0);
    chk("rst_we", bram_we, 0);
    chk("rst_addr", bram_addr, 0);
    chk("rst_wdata", bram_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_full", full, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_small_wr_ptr", s_wr_ptr, 0);

    // VERTEX with operands back to back
    log_en = 1'b1;
    base = log_n;
    send_word(32'h0000_0003, 4, ok);
    chk("vtx_hdr_ok", ok, 1);
    for (int i = 1; i < 4; i++) send_word(32'hA000_0000 + i, 4, ok);
    idle(3);
    chk("vtx_nwrites", log_n - base, 4 + TERM_EN);
    for (int i = 0; i < 4; i++) begin
      chk("vtx_addr", log_addr[base+i], 4 * i);
      chk("vtx_consecutive", log_cyc[base+i] - log_cyc[base], i);
    end
    chk("vtx_last_data", log_data[base+3], 32'hA000_0003);
    chk("vtx_wr_ptr", wr_ptr, 16);
    chk("vtx_model_tail", m_tail, 16);
`ifdef GL_CMD_WRITER_TERM_EN
    chk("vtx_term_addr", log_addr[base+4], 16);
    chk("vtx_term_data", log_data[base+4], 0);
`endif

    // LOADMATRIX then unknown opcode, from a fresh start
    rst_pulse(2);
    base = log_n;
    send_word(32'h0000_0013, 4, ok);
    for (int i = 1; i < 17; i++) send_word(32'hB000_0000 + i, 4, ok);
    idle(3);
    chk("lm_first_addr", log_addr[base], 0);
    chk("lm_last_addr", log_addr[base+16], 64);
    chk("lm_wr_ptr", wr_ptr, 68);
    send_word(32'h1234_56FF, 4, ok);
    idle(3);
    chk("ff_addr", log_addr[base+17+TERM_EN], 68);
    chk("ff_data", log_data[base+17+TERM_EN], 32'h1234_56FF);
    chk("ff_wr_ptr", wr_ptr, 72);
    chk("ff_model_tail", m_tail, 72);

    // reset in the middle of MULTMATRIX
    send_word(32'h0000_0011, 4, ok);
    for (int i = 1; i < 5; i++) send_word(32'hC000_0000 + i, 4, ok);
    chk("mm_wr_ptr_hold", wr_ptr, 72);
    chk("mm_busy", busy, 1);
    rst_pulse(1);
    chk("mm_wr_ptr_reset", wr_ptr, 0);
    chk("mm_busy_reset", busy, 0);
    base = log_n;
    send_word(32'h0000_0003, 4, ok);
    for (int i = 1; i < 4; i++) send_word(32'hD000_0000 + i, 4, ok);
    idle(3);
    chk("mm_restart_addr", log_addr[base], 0);
    chk("mm_restart_wr_ptr", wr_ptr, 16);

    // COLOR from a fresh start
    rst_pulse(1);
    base = log_n;
    send_word(32'h0000_0004, 4, ok);
    for (int i = 1; i < 4; i++) send_word(32'hE000_0000 + i, 4, ok);
    idle(3);
    chk("col_nwrites", log_n - base, 4 + TERM_EN);
    chk("col_wr_ptr", wr_ptr, 16);
`ifdef GL_CMD_WRITER_TERM_EN
    chk("col_term_addr", log_addr[base+4], 16);
    chk("col_term_data", log_data[base+4], 0);
`endif
    log_en = 1'b0;

    // small memory: VIEWPORT fits, FRUSTUM refused
    for (int i = 0; i < 5; i++) begin
      s_data = (i == 0) ? 32'h0000_0019 : 32'h0000_0100 + i;
      s_valid = 1'b1;
      @(negedge clk);
      chk("small_vp_ready", s_ready, 1);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("small_vp_wr_ptr", s_wr_ptr, 20);
    chk("small_vp_busy", s_busy, 0);
    chk("small_vp_full", s_full, 0);
    s_data = 32'h0000_001A; s_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("small_fr_ready", s_ready, 0);
      chk("small_fr_we", s_we, 0);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    chk("small_fr_full", s_full, 1);
    chk("small_fr_wr_ptr", s_wr_ptr, 20);
    // header-only commands still fit; the third ends exactly at the top
    for (int i = 0; i < 3; i++) begin
      s_data = 32'h0000_00FF; s_valid = 1'b1;
      @(negedge clk);
      chk("small_ff_ready", s_ready, 1);
      @(posedge clk); #1;
      s_valid = 1'b0;
      @(negedge clk);
      chk("small_ff_we", s_we, 1);
      chk("small_ff_addr", s_addr, 20 + 4 * i);
      for (int k = 0; k < 2; k++) begin
        @(negedge clk);
        if (i == 2) chk("small_top_no_write", s_we, 0);
      end
      @(posedge clk); #1;
    end
    chk("small_top_wr_ptr", s_wr_ptr, 32);
    s_data = 32'h0000_00FF; s_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("small_over_ready", s_ready, 0);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    chk("small_over_full", s_full, 1);

    // randomized command streams
    rst_pulse(1);
    for (int c = 0; c < 400; c++) begin
      logic [7:0] op;
      int nb;
      if ($urandom_range(0, 1) == 1) op = OPS[$urandom_range(0, 8)];
      else                           op = 8'($urandom);
      nb = bytes_for(op);
      send_word({24'($urandom), op}, 6, ok);
      if (!ok) begin
        rst_pulse($urandom_range(1, 2));
        continue;
      end
      for (int w = 1; w < nb / 4; w++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        if ($urandom_range(0, 80) == 0) begin
          rst_pulse(1);
          break;
        end
        send_word($urandom, 6, ok);
      end
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
